// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the decision-tree sample scheduler.
package rf_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_AVAI,
    S_RUN,
    S_SETTLE,
    S_FINISH
  } sched_state_e;

  // Cycles spent after a completed sample so RAM read-select and availability can update.
  localparam int SETTLE_CYCLES = 2;
  localparam int SETTLE_CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

endpackage

// File: rtl/dtp_sample_scheduler.sv
// Sequences a group of decision-tree processors through a session of samples,
// handshaking with the attribute RAM and guarding the availability wait with a watchdog.
module dtp_sample_scheduler
  import rf_sched_pkg::*;
#(
  parameter int N_DTPS       = 4,
  parameter int SAMPLE_CNT_W = 16,
  parameter int TIMEOUT_W    = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_run,
  input  logic                    i_abort,
  input  logic [SAMPLE_CNT_W-1:0] i_num_samples,
  output logic                    o_att_ram_start,
  output logic                    o_att_ram_end,
  input  logic                    i_is_att_ram_avai,
  input  logic                    i_is_sample_done,
  output logic [N_DTPS-1:0]       o_dtp_start,
  input  logic [N_DTPS-1:0]       i_dtp_done,
  output logic [N_DTPS-1:0]       o_att_ram_switch,
  output logic                    o_busy,
  output logic                    o_session_done,
  output logic [SAMPLE_CNT_W-1:0] o_sample_cnt,
  output logic                    o_timeout_err
);

  sched_state_e            state, nxt;
  logic [SAMPLE_CNT_W-1:0] num_lat;
  logic [SAMPLE_CNT_W-1:0] cnt_inc;
  logic [N_DTPS-1:0]       done_mask;
  logic [N_DTPS-1:0]       done_seen;
  logic [TIMEOUT_W-1:0]    wd;
  logic [TIMEOUT_W-1:0]    wd_inc;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    all_done;
  logic                    wd_expired;
  logic                    settle_last;
  logic                    aborting;

  // Drain status is advisory only: the availability wait already covers it.
  logic unused_sample_done;
  assign unused_sample_done = i_is_sample_done;

  assign done_seen   = done_mask | i_dtp_done;
  assign all_done    = &done_seen;
  assign cnt_inc     = o_sample_cnt + SAMPLE_CNT_W'(1);
  assign wd_inc      = wd + TIMEOUT_W'(1);
  assign wd_expired  = &wd_inc;
  assign settle_last = (settle_cnt == SETTLE_CNT_W'(SETTLE_CYCLES - 1));
  assign aborting    = i_abort && (state inside {S_WAIT_AVAI, S_RUN, S_SETTLE});

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      if (i_run) nxt = (i_num_samples == '0) ? S_FINISH : S_WAIT_AVAI;
      S_WAIT_AVAI: begin
        if (i_is_att_ram_avai) nxt = S_RUN;
        else if (wd_expired)   nxt = S_FINISH;
      end
      S_RUN:       if (all_done) nxt = (cnt_inc == num_lat) ? S_FINISH : S_SETTLE;
      S_SETTLE:    if (settle_last) nxt = S_WAIT_AVAI;
      S_FINISH:    nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
    if (aborting) nxt = S_FINISH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      num_lat          <= '0;
      done_mask        <= '0;
      wd               <= '0;
      settle_cnt       <= '0;
      o_busy           <= 1'b0;
      o_att_ram_start  <= 1'b0;
      o_att_ram_end    <= 1'b0;
      o_session_done   <= 1'b0;
      o_dtp_start      <= '0;
      o_att_ram_switch <= '0;
      o_sample_cnt     <= '0;
      o_timeout_err    <= 1'b0;
    end else begin
      state            <= nxt;
      // Outputs decoded from the next state so they line up with the state register.
      o_busy           <= (nxt != S_IDLE);
      o_att_ram_start  <= (nxt == S_WAIT_AVAI);
      o_att_ram_end    <= (nxt == S_FINISH);
      o_session_done   <= (nxt == S_FINISH);
      o_dtp_start      <= (state == S_WAIT_AVAI && nxt == S_RUN) ? '1 : '0;
      o_att_ram_switch <= (state == S_RUN) ? (i_dtp_done & ~done_mask) : '0;

      case (state)
        S_IDLE: begin
          if (i_run) begin
            num_lat       <= i_num_samples;
            o_sample_cnt  <= '0;
            o_timeout_err <= 1'b0;
          end
        end
        S_WAIT_AVAI: begin
          if (!i_is_att_ram_avai) begin
            wd <= wd_inc;
            if (wd_expired && !i_abort) o_timeout_err <= 1'b1;
          end
        end
        S_RUN: begin
          done_mask <= done_seen;
          if (all_done && !i_abort) o_sample_cnt <= cnt_inc;
        end
        S_SETTLE: settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
        default: ;
      endcase

      // Entry initialisation overrides the per-state updates above.
      if (nxt == S_WAIT_AVAI && state != S_WAIT_AVAI) wd <= '0;
      if (nxt == S_RUN && state != S_RUN) begin
        done_mask <= '0;
        wd        <= '0;
      end
      if (nxt == S_SETTLE && state != S_SETTLE) settle_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dtp_sample_scheduler.sv
// Directed bench for dtp_sample_scheduler: session flow, empty session, watchdog,
// duplicate/stray done pulses, abort on completion and mid-session reset.
module tb_dtp_sample_scheduler;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_run;
  logic          i_abort;
  logic [CW-1:0] i_num_samples;
  logic          o_att_ram_start;
  logic          o_att_ram_end;
  logic          i_is_att_ram_avai;
  logic          i_is_sample_done;
  logic [N-1:0]  o_dtp_start;
  logic [N-1:0]  i_dtp_done;
  logic [N-1:0]  o_att_ram_switch;
  logic          o_busy;
  logic          o_session_done;
  logic [CW-1:0] o_sample_cnt;
  logic          o_timeout_err;

  int errors = 0;
  int checks = 0;
  int n_dstart = 0, n_end = 0, n_sdone = 0, n_rstart = 0;
  int e0, s0, d0, r0;

  always #5 clk = ~clk;

  dtp_sample_scheduler #(
    .N_DTPS(N), .SAMPLE_CNT_W(CW), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_abort(i_abort),
    .i_num_samples(i_num_samples),
    .o_att_ram_start(o_att_ram_start), .o_att_ram_end(o_att_ram_end),
    .i_is_att_ram_avai(i_is_att_ram_avai), .i_is_sample_done(i_is_sample_done),
    .o_dtp_start(o_dtp_start), .i_dtp_done(i_dtp_done),
    .o_att_ram_switch(o_att_ram_switch), .o_busy(o_busy),
    .o_session_done(o_session_done), .o_sample_cnt(o_sample_cnt),
    .o_timeout_err(o_timeout_err)
  );

  // Pulse counters; each edge sees the value held during the preceding cycle.
  always @(posedge clk) begin
    if (o_dtp_start == '1)  n_dstart <= n_dstart + 1;
    if (o_att_ram_end)      n_end    <= n_end + 1;
    if (o_session_done)     n_sdone  <= n_sdone + 1;
    if (o_att_ram_start)    n_rstart <= n_rstart + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(o_busy), 0);
    chk({tag, "_rstart"}, 32'(o_att_ram_start), 0);
    chk({tag, "_end"},    32'(o_att_ram_end), 0);
    chk({tag, "_sdone"},  32'(o_session_done), 0);
    chk({tag, "_dstart"}, 32'(o_dtp_start), 0);
    chk({tag, "_switch"}, 32'(o_att_ram_switch), 0);
    chk({tag, "_cnt"},    32'(o_sample_cnt), 0);
    chk({tag, "_err"},    32'(o_timeout_err), 0);
  endtask

  // Entered just after the edge that put the DUT in WAIT_AVAI.
  task automatic do_sample(input int wcyc, input bit last, input int exp_cnt);
    chk("wait_ram_start", 32'(o_att_ram_start), 1);
    repeat (wcyc) tick;
    i_is_att_ram_avai = 1'b1;
    tick;
    i_is_att_ram_avai = 1'b0;
    chk("run_dtp_start", 32'(o_dtp_start), 32'hF);
    chk("run_ram_start_low", 32'(o_att_ram_start), 0);
    for (int i = 0; i < N; i++) begin
      i_dtp_done = N'(1 << i);
      tick;
      chk("switch_after_done", 32'(o_att_ram_switch), 32'(1 << i));
      if (i == 0) chk("dtp_start_single", 32'(o_dtp_start), 0);
    end
    i_dtp_done = '0;
    chk("sample_cnt", 32'(o_sample_cnt), 32'(exp_cnt));
    chk("end_pulse", 32'(o_att_ram_end), 32'(last));
    tick;
    chk("switch_clear", 32'(o_att_ram_switch), 0);
    if (last) chk("idle_after_finish", 32'(o_busy), 0);
    else begin
      chk("settle_ram_start_low", 32'(o_att_ram_start), 0);
      tick;
    end
  endtask

  initial begin
    rst = 1'b1; i_run = 1'b0; i_abort = 1'b0; i_num_samples = '0;
    i_is_att_ram_avai = 1'b0; i_is_sample_done = 1'b0; i_dtp_done = '0;
    tick; tick;
    chk_all_zero("reset");
    rst = 1'b0;
    tick;

    // Three-sample session, availability after a few cycles.
    e0 = n_end; s0 = n_sdone; d0 = n_dstart;
    i_num_samples = 16'd3; i_run = 1'b1;
    tick;
    i_run = 1'b0;
    chk("s3_busy", 32'(o_busy), 1);
    i_is_sample_done = 1'b1;
    do_sample(4, 1'b0, 1);
    i_is_sample_done = 1'b0;
    do_sample(4, 1'b0, 2);
    do_sample(4, 1'b1, 3);
    tick;
    chk("s3_end_pulses", 32'(n_end - e0), 1);
    chk("s3_sdone_pulses", 32'(n_sdone - s0), 1);
    chk("s3_start_pulses", 32'(n_dstart - d0), 3);
    chk("s3_cnt_held", 32'(o_sample_cnt), 3);

    // Empty session.
    r0 = n_rstart; e0 = n_end;
    i_num_samples = 16'd0; i_run = 1'b1;
    tick;
    i_run = 1'b0;
    chk("zero_end", 32'(o_att_ram_end), 1);
    chk("zero_sdone", 32'(o_session_done), 1);
    chk("zero_rstart", 32'(o_att_ram_start), 0);
    chk("zero_cnt", 32'(o_sample_cnt), 0);
    tick;
    chk("zero_idle", 32'(o_busy), 0);
    tick;
    chk("zero_rstart_never", 32'(n_rstart - r0), 0);
    chk("zero_end_count", 32'(n_end - e0), 1);

    // Watchdog: fifteen cycles in WAIT_AVAI without availability.
    i_num_samples = 16'd2; i_run = 1'b1;
    tick;
    i_run = 1'b0;
    repeat (14) tick;
    chk("wd_still_waiting", 32'(o_att_ram_start), 1);
    chk("wd_no_err_yet", 32'(o_timeout_err), 0);
    tick;
    chk("wd_err", 32'(o_timeout_err), 1);
    chk("wd_end", 32'(o_att_ram_end), 1);
    chk("wd_left_wait", 32'(o_att_ram_start), 0);
    tick;
    chk("wd_idle", 32'(o_busy), 0);
    chk("wd_err_sticky", 32'(o_timeout_err), 1);

    // Duplicate done and stray done during SETTLE.
    i_num_samples = 16'd2; i_run = 1'b1;
    tick;
    i_run = 1'b0;
    chk("dup_err_cleared", 32'(o_timeout_err), 0);
    i_is_att_ram_avai = 1'b1; tick; i_is_att_ram_avai = 1'b0;
    i_dtp_done = 4'b0001; tick;
    chk("dup_sw0", 32'(o_att_ram_switch), 32'b0001);
    i_dtp_done = 4'b0010; tick;
    chk("dup_sw1", 32'(o_att_ram_switch), 32'b0010);
    i_dtp_done = 4'b0010; tick;
    chk("dup_sw1_repeat", 32'(o_att_ram_switch), 0);
    i_dtp_done = 4'b0100; tick;
    chk("dup_sw2", 32'(o_att_ram_switch), 32'b0100);
    chk("dup_cnt_mid", 32'(o_sample_cnt), 0);
    i_dtp_done = 4'b1000; tick;
    chk("dup_sw3", 32'(o_att_ram_switch), 32'b1000);
    chk("dup_cnt", 32'(o_sample_cnt), 1);
    i_dtp_done = 4'b0010; tick;
    chk("settle_done_ignored", 32'(o_att_ram_switch), 0);
    chk("settle_cnt_same", 32'(o_sample_cnt), 1);
    i_dtp_done = '0; tick;
    do_sample(1, 1'b1, 2);

    // Abort coinciding with the last done of sample 2 of 4.
    i_num_samples = 16'd4; i_run = 1'b1;
    tick;
    i_run = 1'b0;
    do_sample(2, 1'b0, 1);
    i_is_att_ram_avai = 1'b1; tick; i_is_att_ram_avai = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_dtp_done = N'(1 << i);
      tick;
    end
    i_dtp_done = 4'b1000; i_abort = 1'b1;
    tick;
    i_dtp_done = '0; i_abort = 1'b0;
    chk("abort_no_inc", 32'(o_sample_cnt), 1);
    chk("abort_finish", 32'(o_att_ram_end), 1);
    chk("abort_switch_kept", 32'(o_att_ram_switch), 32'b1000);
    tick;
    chk("abort_idle", 32'(o_busy), 0);
    chk("abort_cnt_held", 32'(o_sample_cnt), 1);

    // Reset asserted mid-RUN, then a clean session.
    i_num_samples = 16'd2; i_run = 1'b1;
    tick;
    i_run = 1'b0;
    i_is_att_ram_avai = 1'b1; tick; i_is_att_ram_avai = 1'b0;
    i_dtp_done = 4'b0001; tick;
    e0 = n_end;
    i_dtp_done = 4'b0010; rst = 1'b1;
    tick;
    rst = 1'b0; i_dtp_done = '0;
    chk_all_zero("rst_run");
    tick;
    chk("rst_no_end", 32'(n_end - e0), 0);
    i_num_samples = 16'd1; i_run = 1'b1;
    tick;
    i_run = 1'b0;
    do_sample(0, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
